toy_cpu_sequencer: RTL and testbench

Program buffer and issue sequencer for the toy CPU core. It captures 20-bit instruction words from the 6-bit pad bus into a small program buffer. On command it replays the buffer to the core's decoded-instruction port (op_valid/opcode/src_a/src_b/dest/imm), one instruction per cycle, with an optional repeat count. It sits between the pad inputs and the core, in place of direct single-shot fetch.

---
 rtl/toy_cpu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_toy_cpu_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_cpu_sequencer.sv
// Program buffer and issue sequencer: captures 20-bit words from the 6-bit pad bus, replays them to the core.
// Optional repeat count on RUN is enabled by defining SEQ_REPEAT_EN.
module toy_cpu_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] in,
    output logic       op_valid,
    output logic [2:0] opcode,
    output logic [2:0] src_a,
    output logic [2:0] src_b,
    output logic [2:0] dest,
    output logic [7:0] imm,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_RUN   = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b011;
    localparam logic [2:0] CMD_ABORT = 3'b111;

    typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, LOAD2, LOAD3, RUN} state_t;

    state_t          state_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [17:0]     stage_reg;
    logic            op_valid_reg;
    logic [19:0]     issue_reg;
    logic            busy_reg;
    logic            full_reg;
    logic            overflow_reg;
    logic [19:0]     buffer [DEPTH];

    logic            wr_en;
    logic [19:0]     wr_word;
    logic [AW-1:0]   rd_addr;
    logic [19:0]     rd_word;
    logic            last_entry;
    logic            rep_done;
    logic [2:0]      cmd;

    assign cmd        = in[5:3];
    assign wr_word    = {stage_reg, in[5:4]};
    assign wr_en      = (state_reg == LOAD3) && !full_reg && !rst;
    assign last_entry = (CW'(rd_ptr_reg) == count_reg - CW'(1));

`ifdef SEQ_REPEAT_EN
    logic [2:0] rep_reg;
    assign rep_done = (rep_reg == 3'd0);
`else
    assign rep_done = 1'b1;
`endif

    // Address of the entry the output register captures at the next edge.
    always_comb begin
        rd_addr = '0;
        if (state_reg == RUN && !last_entry)
            rd_addr = rd_ptr_reg + AW'(1);
        rd_word = buffer[rd_addr];
    end

    // Buffer has no reset: its contents survive rst and CLEAR, count alone marks validity.
    always_ff @(posedge clk) begin
        if (wr_en)
            buffer[wr_ptr_reg] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            stage_reg    <= '0;
            op_valid_reg <= 1'b0;
            issue_reg    <= '0;
            busy_reg     <= 1'b0;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
`ifdef SEQ_REPEAT_EN
            rep_reg      <= 3'd0;
`endif
        end else begin
            op_valid_reg <= 1'b0;
            issue_reg    <= '0;
            case (state_reg)
                IDLE: begin
                    case (cmd)
                        CMD_LOAD: begin
                            state_reg <= LOAD0;
                            busy_reg  <= 1'b1;
                        end
                        CMD_RUN: begin
                            if (count_reg != '0) begin
                                state_reg    <= RUN;
                                busy_reg     <= 1'b1;
                                rd_ptr_reg   <= '0;
                                op_valid_reg <= 1'b1;
                                issue_reg    <= rd_word;
`ifdef SEQ_REPEAT_EN
                                rep_reg      <= in[2:0];
`endif
                            end
                        end
                        CMD_CLEAR: begin
                            wr_ptr_reg   <= '0;
                            count_reg    <= '0;
                            full_reg     <= 1'b0;
                            overflow_reg <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                LOAD0: begin
                    stage_reg[17:12] <= in;
                    state_reg        <= LOAD1;
                end
                LOAD1: begin
                    stage_reg[11:6] <= in;
                    state_reg       <= LOAD2;
                end
                LOAD2: begin
                    stage_reg[5:0] <= in;
                    state_reg      <= LOAD3;
                end
                LOAD3: begin
                    if (!full_reg) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                        count_reg  <= count_reg + CW'(1);
                        full_reg   <= (count_reg + CW'(1) == FULL_CNT);
                    end else begin
                        overflow_reg <= 1'b1;
                    end
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                RUN: begin
                    // The word on the outputs this cycle is always delivered; abort only stops the next one.
                    if (cmd == CMD_ABORT || (last_entry && rep_done)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        op_valid_reg <= 1'b1;
                        issue_reg    <= rd_word;
                        rd_ptr_reg   <= last_entry ? '0 : rd_ptr_reg + AW'(1);
`ifdef SEQ_REPEAT_EN
                        if (last_entry)
                            rep_reg <= rep_reg - 3'd1;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign op_valid = op_valid_reg;
    assign opcode   = issue_reg[19:17];
    assign src_a    = issue_reg[16:14];
    assign src_b    = issue_reg[13:11];
    assign dest     = issue_reg[10:8];
    assign imm      = issue_reg[7:0];
    assign busy     = busy_reg;
    assign full     = full_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_toy_cpu_sequencer.sv
// Randomized self-checking bench for toy_cpu_sequencer against a queue-based program model.
module tb_toy_cpu_sequencer;
    localparam int DEPTH = 8;

    typedef logic [19:0] word_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] in;
    logic       op_valid;
    logic [2:0] opcode, src_a, src_b, dest;
    logic [7:0] imm;
    logic       busy, full, overflow;

    int vectors = 0;
    int miscompares = 0;

    word_q_t prog;
    bit      ovf_m;

    always #5 clk = ~clk;

    toy_cpu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in(in),
        .op_valid(op_valid), .opcode(opcode), .src_a(src_a), .src_b(src_b),
        .dest(dest), .imm(imm), .busy(busy), .full(full), .overflow(overflow)
    );

    // Entered and left at a falling edge; the value is sampled at the rising edge in between.
    task automatic step(input logic [5:0] v);
        in = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        prog.delete();
        ovf_m = 1'b0;
    endtask

    task automatic do_clear();
        step({3'b011, 3'($urandom)});
        model_clear();
    endtask

    task automatic load_word(input logic [19:0] w);
        step({3'b001, 3'($urandom)});
        step(w[19:14]);
        step(w[13:8]);
        step(w[7:2]);
        step({w[1:0], 4'($urandom)});
        if (prog.size() < DEPTH) prog.push_back(w);
        else ovf_m = 1'b1;
    endtask

    // Expected issue stream: the program replayed rep+1 times, truncated after an abort.
    task automatic model_issues(input int rep, input int abort_k, output word_q_t q);
        int laps;
        int total;
        q = {};
`ifdef SEQ_REPEAT_EN
        laps = rep + 1;
`else
        laps = 1;
`endif
        total = prog.size() * laps;
        if (abort_k >= 0 && abort_k + 1 < total) total = abort_k + 1;
        for (int i = 0; i < total; i++) q.push_back(prog[i % prog.size()]);
    endtask

    task automatic run_capture(input int rep, input int abort_k, output word_q_t obs,
                               output bit busy_ok, output logic busy_end);
        int n = 0;
        logic [5:0] v;
        obs = {};
        busy_ok = 1'b1;
        step({3'b010, 3'(rep)});
        while (op_valid === 1'b1 && n < 200) begin
            obs.push_back({opcode, src_a, src_b, dest, imm});
            if (busy !== 1'b1) busy_ok = 1'b0;
            v = 6'($urandom);
            if (v[5:3] == 3'b111) v[5] = 1'b0;
            if (n == abort_k) v = {3'b111, v[2:0]};
            n++;
            step(v);
        end
        busy_end = busy;
    endtask

    task automatic test_reset();
        word_q_t obs;
        bit      bok;
        logic    bend;
        rst = 1'b1;
        in  = 6'h3F;
        @(negedge clk);
        step(6'h3F);
        step(6'h3F);
        vectors++;
        if ({op_valid, opcode, src_a, src_b, dest, imm, busy, full, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 0", {op_valid, opcode, src_a, src_b, dest, imm, busy, full, overflow});
        end
        rst = 1'b0;
        model_clear();
        run_capture(0, -1, obs, bok, bend);
        vectors++;
        if (obs.size() != 0 || bend !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_empty_run: got %0d issues busy=%b required 0 issues busy=0", obs.size(), bend);
        end
        $display("reset: outputs cleared, empty RUN issued %0d", obs.size());
    endtask

    task automatic test_load_run_once();
        word_q_t obs, exp;
        bit      bok;
        logic    bend;
        logic [19:0] w;
        w = {3'd3, 3'd1, 3'd2, 3'd4, 8'hA5};
        do_clear();
        load_word(w);
        vectors++;
        if ({busy, full, overflow, op_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL load_once_status: got %b required 0000", {busy, full, overflow, op_valid});
        end
        model_issues(0, -1, exp);
        run_capture(0, -1, obs, bok, bend);
        vectors++;
        if (obs.size() != 1 || obs[0] !== w) begin
            miscompares++;
            $display("FAIL run_once: got %0d issues first=%h required 1 issue %h", obs.size(), (obs.size() > 0) ? obs[0] : 20'h0, w);
        end
        vectors++;
        if ({bok, bend, opcode, src_a, src_b, dest, imm} !== {1'b1, 1'b0, 20'h0}) begin
            miscompares++;
            $display("FAIL run_once_after: busy_ok=%b busy=%b fields=%h required 1 0 00000", bok, bend, {opcode, src_a, src_b, dest, imm});
        end
        $display("load_run_once: issued %0d word(s), expected %0d", obs.size(), exp.size());
    endtask

    task automatic test_repeat();
        word_q_t obs, exp;
        bit      bok;
        logic    bend;
        do_clear();
        for (int i = 0; i < 3; i++) load_word(20'($urandom));
        model_issues(2, -1, exp);
        run_capture(2, -1, obs, bok, bend);
        vectors++;
        if (obs.size() != exp.size() || !bok || bend !== 1'b0) begin
            miscompares++;
            $display("FAIL repeat_len: got %0d issues busy_ok=%b busy=%b required %0d 1 0", obs.size(), bok, bend, exp.size());
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL repeat_word[%0d]: got %h required %h", i, obs[i], exp[i]);
            end
        end
        $display("repeat: rep=2 issued %0d, expected %0d", obs.size(), exp.size());
    endtask

    task automatic test_full_overflow();
        word_q_t obs, exp;
        bit      bok;
        logic    bend;
        do_clear();
        for (int i = 0; i < DEPTH; i++) load_word(20'($urandom));
        vectors++;
        if ({full, overflow} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_set: got full=%b overflow=%b required 1 0", full, overflow);
        end
        load_word(20'($urandom));
        vectors++;
        if ({full, overflow} !== 2'b11) begin
            miscompares++;
            $display("FAIL overflow_set: got full=%b overflow=%b required 1 1", full, overflow);
        end
        model_issues(0, -1, exp);
        run_capture(0, -1, obs, bok, bend);
        vectors++;
        if (obs.size() != exp.size()) begin
            miscompares++;
            $display("FAIL full_run_len: got %0d required %0d", obs.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL full_run_word[%0d]: got %h required %h", i, obs[i], exp[i]);
            end
        end
        do_clear();
        vectors++;
        if ({full, overflow} !== 2'b00) begin
            miscompares++;
            $display("FAIL clear_flags: got full=%b overflow=%b required 0 0", full, overflow);
        end
        $display("full_overflow: ran %0d of %0d entries, flags cleared", obs.size(), DEPTH);
    endtask

    task automatic test_abort();
        word_q_t obs, exp;
        bit      bok;
        logic    bend;
        do_clear();
        for (int i = 0; i < 4; i++) load_word(20'($urandom));
        model_issues(0, 1, exp);
        run_capture(0, 1, obs, bok, bend);
        vectors++;
        if (obs.size() != 2 || obs.size() != exp.size() || bend !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_len: got %0d issues busy=%b required 2 busy=0", obs.size(), bend);
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL abort_word[%0d]: got %h required %h", i, obs[i], exp[i]);
            end
        end
        // Command driven in the cycle right after the abort must be taken.
        model_issues(0, -1, exp);
        run_capture(0, -1, obs, bok, bend);
        vectors++;
        if (obs.size() != exp.size()) begin
            miscompares++;
            $display("FAIL abort_next_cmd: got %0d issues required %0d", obs.size(), exp.size());
        end
        $display("abort: aborted run then rerun issued %0d, expected %0d", obs.size(), exp.size());
    endtask

    task automatic test_reset_mid_load();
        word_q_t obs;
        bit      bok;
        logic    bend;
        logic [19:0] w;
        step({3'b001, 3'b000});
        step(6'($urandom));
        step(6'($urandom));
        rst = 1'b1;
        step(6'($urandom));
        rst = 1'b0;
        model_clear();
        vectors++;
        if ({busy, full, overflow, op_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midload_status: got %b required 0000", {busy, full, overflow, op_valid});
        end
        run_capture(0, -1, obs, bok, bend);
        vectors++;
        if (obs.size() != 0) begin
            miscompares++;
            $display("FAIL midload_count: got %0d issues required 0", obs.size());
        end
        w = 20'($urandom);
        load_word(w);
        run_capture(0, -1, obs, bok, bend);
        vectors++;
        if (obs.size() != 1 || obs[0] !== w) begin
            miscompares++;
            $display("FAIL midload_new_word: got %0d issues first=%h required 1 issue %h", obs.size(), (obs.size() > 0) ? obs[0] : 20'h0, w);
        end
        $display("reset_mid_load: partial word dropped, new run issued %0d", obs.size());
    endtask

    task automatic test_random();
        word_q_t obs, exp;
        bit      bok;
        logic    bend;
        int      n, rep, abort_k;
        for (int it = 0; it < 8; it++) begin
            do_clear();
            n = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < n; i++) load_word(20'($urandom));
            vectors++;
            if ({full, overflow} !== {prog.size() == DEPTH, ovf_m}) begin
                miscompares++;
                $display("FAIL rand_flags[%0d]: got full=%b overflow=%b required %b %b", it, full, overflow, prog.size() == DEPTH, ovf_m);
            end
            rep = $urandom_range(0, 7);
            abort_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            model_issues(rep, abort_k, exp);
            run_capture(rep, abort_k, obs, bok, bend);
            vectors++;
            if (obs.size() != exp.size() || !bok || bend !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_len[%0d]: got %0d busy_ok=%b busy=%b required %0d 1 0", it, obs.size(), bok, bend, exp.size());
            end
            for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
                vectors++;
                if (obs[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL rand_word[%0d][%0d]: got %h required %h", it, i, obs[i], exp[i]);
                end
            end
            $display("random[%0d]: loaded %0d rep=%0d abort=%0d issued %0d expected %0d", it, n, rep, abort_k, obs.size(), exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_run_once();
        test_repeat();
        test_full_overflow();
        test_abort();
        test_reset_mid_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
